// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for the 16-bit datapath.
// It captures an operand, a 2-bit shift code and a step count. It then issues
// the single-bit shift code once per cycle while stepping an internal working
// register. It returns the result on dout together with a one-cycle done pulse.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       shift
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   work_r;
  logic [1:0]         op_q_r;
  logic [AMT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   dout_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   step_s;
  logic [1:0]         shift_s;

  // One single-bit step of the datapath shift-code encoding.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       code);
    logic [WIDTH-1:0] r;
    case (code)
      2'b01:   r = {v[WIDTH-2:0], 1'b0};
      2'b10:   r = {1'b0, v[WIDTH-1:1]};
      2'b11:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Next working value for the current SHIFT cycle.
  always_comb begin
    step_s = shift_step(work_r, op_q_r);
  end

  // Issued shift code: the captured code while stepping, pass otherwise.
  always_comb begin
    shift_s = 2'b00;
    if (state_r == SHIFT) begin
      shift_s = op_q_r;
    end else begin
      shift_s = 2'b00;
    end
  end

  // Control FSM with the working register and the registered status and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= {WIDTH{1'b0}};
      op_q_r  <= 2'b00;
      cnt_r   <= {AMT_W{1'b0}};
      dout_r  <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            work_r <= din;
            op_q_r <= op;
            cnt_r  <= amount;
            busy_r <= 1'b1;
            // A pass code or a zero count needs no stepping.
            if ((op == 2'b00) || (amount == {AMT_W{1'b0}})) begin
              dout_r  <= din;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r - {{(AMT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
            dout_r  <= step_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign dout  = dout_r;
  assign shift = shift_s;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with hand-computed expected values.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic [1:0]  shift;

  int total;
  int bad;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .amount (amount),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .dout   (dout),
    .shift  (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion.
  // The start request is optionally held high throughout the operation.
  // n_exp counts the cycles from the capture edge to done.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] o,
                        input logic [3:0] a, input int n_exp, input logic [15:0] r_exp,
                        input bit hold_start);
    int cyc;
    int nz_any;
    int nz_ok;
    int busy_low;
    din = d; op = o; amount = a; start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    cyc = 0; nz_any = 0; nz_ok = 0; busy_low = 0;
    while (!done && cyc < 40) begin
      if (shift !== 2'b00) nz_any++;
      if (shift === o) nz_ok++;
      if (busy !== 1'b1) busy_low++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, n_exp);
    check({tag, "_shift_cycles"}, nz_any, n_exp);
    check({tag, "_shift_code"}, nz_ok, (o == 2'b00) ? 0 : n_exp);
    check({tag, "_busy_held"}, busy_low, 0);
    check({tag, "_dout"}, dout, r_exp);
    check({tag, "_busy_in_done"}, busy, 1'b1);
    check({tag, "_shift_in_done"}, shift, 2'b00);
    tick();
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_dout_hold"}, dout, r_exp);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; amount = 4'd0; din = 16'h0000;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 16'h0000);
    check("rst_shift", shift, 2'b00);
    #10;
    rst_n = 1'b1;
    tick();

    // Left 4: 0x0001 -> 0x0010.
    run_op("lsl4", 16'h0001, 2'b01, 4'd4, 4, 16'h0010, 1'b0);
    // Arithmetic and logical right by 15 on 0x8000.
    run_op("asr15", 16'h8000, 2'b11, 4'd15, 15, 16'hFFFF, 1'b0);
    run_op("lsr15", 16'h8000, 2'b10, 4'd15, 15, 16'h0001, 1'b0);
    // Pass code and zero count both finish right after capture.
    run_op("pass", 16'hA5A5, 2'b00, 4'd7, 0, 16'hA5A5, 1'b0);
    run_op("zero_amt", 16'hA5A5, 2'b01, 4'd0, 0, 16'hA5A5, 1'b0);

    // Start held high throughout; din changed during busy must not be recaptured.
    din = 16'h00F0; op = 2'b10; amount = 4'd3; start = 1'b1;
    tick();
    din = 16'h0F00;
    for (int i = 0; i < 3; i++) begin
      check("spam_no_done", done, 1'b0);
      tick();
    end
    check("spam_done", done, 1'b1);
    check("spam_dout", dout, 16'h001E);
    tick();
    check("spam_idle_busy", busy, 1'b0);
    check("spam_idle_dout", dout, 16'h001E);
    // Start is still high, so this idle cycle captures 0x0F00.
    run_op("spam_next", 16'h0F00, 2'b10, 4'd3, 3, 16'h01E0, 1'b1);
    start = 1'b0;
    tick();
    check("spam_quiet", busy, 1'b0);

    // Reset at edge 2 of a left-by-8 operation.
    din = 16'h0001; op = 2'b01; amount = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dout", dout, 16'h0000);
    check("mid_rst_shift", shift, 2'b00);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done === 1'b1) done_seen++;
      end
      check("mid_rst_no_done", done_seen, 0);
    end
    check("mid_rst_idle", busy, 1'b0);
    run_op("after_rst", 16'h1234, 2'b01, 4'd2, 2, 16'h48D0, 1'b0);

    // Back-to-back operations.
    run_op("b2b_a", 16'h0003, 2'b01, 4'd1, 1, 16'h0006, 1'b0);
    run_op("b2b_b", 16'hFFFE, 2'b11, 4'd1, 1, 16'hFFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
